// File: rtl/relogio_pkg.sv
// Shared types and field limits for the timekeeping/adjust controller.
// The optional AUTOREPEAT_EN macro is consumed by relogio_ajuste_ctrl.
package relogio_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    AJ_HORA = 2'b01,
    AJ_MIN  = 2'b10,
    AJ_SEG  = 2'b11
  } modo_t;

  localparam logic [5:0] MAX_SEG  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [5:0] MAX_HORA = 6'd23;

  function automatic modo_t next_modo(input modo_t m);
    unique case (m)
      NORMAL:  next_modo = AJ_HORA;
      AJ_HORA: next_modo = AJ_MIN;
      AJ_MIN:  next_modo = AJ_SEG;
      default: next_modo = NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/relogio_mod_counter.sv
// Modulo-(MAX+1) up/down field counter; o_carry flags an increment at MAX
// so the next field can advance in the same cycle.
import relogio_pkg::*;

module relogio_mod_counter #(
  parameter logic [5:0] MAX = MAX_SEG
) (
  input  logic       i_clk,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic       i_dec,
  output logic [5:0] o_value,
  output logic       o_carry
);

  logic [5:0] r_value;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_value <= 6'd0;
    end else if (i_inc && !i_dec) begin
      r_value <= (r_value == MAX) ? 6'd0 : r_value + 6'd1;
    end else if (i_dec && !i_inc) begin
      r_value <= (r_value == 6'd0) ? MAX : r_value - 6'd1;
    end
  end

  assign o_value = r_value;
  assign o_carry = i_inc && !i_dec && (r_value == MAX);

endmodule

// File: rtl/relogio_ajuste_ctrl.sv
// HH:MM:SS timekeeping with 1 Hz prescaler and modo/mais/menos adjust FSM.
// Define AUTOREPEAT_EN to add hold-to-repeat on mais/menos in adjust modes.
import relogio_pkg::*;

module relogio_ajuste_ctrl #(
  parameter int TICKS_PER_SEC = 100_000_000
`ifdef AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
`endif
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       btn_modo,
  input  logic       btn_mais,
  input  logic       btn_menos,
  output logic [5:0] segundos,
  output logic [5:0] minutos,
  output logic [5:0] horas,
  output logic [1:0] modo_ajuste,
  output logic       tick_1hz
);

  localparam int PW = $clog2(TICKS_PER_SEC + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  modo_t         r_modo, w_modo_next;
  logic [PW-1:0] r_presc;
  logic          r_tick;
  logic          r_armed, r_modo_q, r_mais_q, r_menos_q;
  logic          w_modo_edge, w_mais_edge, w_menos_edge;
  logic          w_rep_mais, w_rep_menos;
  logic          w_adj, w_exit, w_up, w_dn;
  logic          w_seg_inc, w_seg_dec, w_min_inc, w_min_dec, w_hora_inc, w_hora_dec;
  logic          w_seg_carry, w_min_carry;

  // Edges are masked for the first cycle after reset so a button already held
  // through reset does not register as a fresh press.
  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      r_armed   <= 1'b0;
      r_modo_q  <= 1'b0;
      r_mais_q  <= 1'b0;
      r_menos_q <= 1'b0;
    end else begin
      r_armed   <= 1'b1;
      r_modo_q  <= btn_modo;
      r_mais_q  <= btn_mais;
      r_menos_q <= btn_menos;
    end
  end

  assign w_modo_edge  = r_armed && btn_modo  && !r_modo_q;
  assign w_mais_edge  = r_armed && btn_mais  && !r_mais_q;
  assign w_menos_edge = r_armed && btn_menos && !r_menos_q;

  assign w_adj  = (r_modo != NORMAL);
  assign w_exit = (r_modo == AJ_SEG) && w_modo_edge;

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      r_modo <= NORMAL;
    end else begin
      r_modo <= w_modo_next;
    end
  end

  always_comb begin
    w_modo_next = r_modo;
    if (w_modo_edge) begin
      w_modo_next = next_modo(r_modo);
    end
  end

  // Leaving adjust restarts the second so the first NORMAL tick is a full period away.
  always_ff @(posedge clk_100MHz) begin
    if (!reset || w_exit) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
      r_tick  <= (r_presc == PRESC_LAST);
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam logic [RW-1:0] REP_FIRE   = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [RW-1:0] r_rep_cnt;
  logic          w_rep_hold, w_rep_pulse;

  // Counter holds cycles since the press; 0 means idle (no repeat armed).
  assign w_rep_hold  = w_adj && r_armed && (btn_mais ^ btn_menos) && !w_modo_edge;
  assign w_rep_pulse = w_rep_hold && !w_mais_edge && !w_menos_edge && (r_rep_cnt == REP_FIRE);
  assign w_rep_mais  = w_rep_pulse && btn_mais;
  assign w_rep_menos = w_rep_pulse && btn_menos;

  always_ff @(posedge clk_100MHz) begin
    if (!reset || !w_rep_hold) begin
      r_rep_cnt <= '0;
    end else if (w_mais_edge || w_menos_edge) begin
      r_rep_cnt <= RW'(1);
    end else if (r_rep_cnt == REP_FIRE) begin
      r_rep_cnt <= REP_RELOAD;
    end else if (r_rep_cnt != '0) begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_mais  = 1'b0;
  assign w_rep_menos = 1'b0;
`endif

  // A coincident modo edge or opposing button cancels the field adjustment.
  assign w_up = w_adj && !w_modo_edge && (w_mais_edge || w_rep_mais) && !(w_menos_edge || w_rep_menos);
  assign w_dn = w_adj && !w_modo_edge && (w_menos_edge || w_rep_menos) && !(w_mais_edge || w_rep_mais);

  assign w_seg_inc  = ((r_modo == NORMAL) && r_tick) || ((r_modo == AJ_SEG) && w_up);
  assign w_seg_dec  = (r_modo == AJ_SEG) && w_dn;
  assign w_min_inc  = ((r_modo == NORMAL) && w_seg_carry) || ((r_modo == AJ_MIN) && w_up);
  assign w_min_dec  = (r_modo == AJ_MIN) && w_dn;
  assign w_hora_inc = ((r_modo == NORMAL) && w_min_carry) || ((r_modo == AJ_HORA) && w_up);
  assign w_hora_dec = (r_modo == AJ_HORA) && w_dn;

  relogio_mod_counter #(.MAX(MAX_SEG)) u_seg (
    .i_clk   (clk_100MHz),
    .i_clr   (!reset),
    .i_inc   (w_seg_inc),
    .i_dec   (w_seg_dec),
    .o_value (segundos),
    .o_carry (w_seg_carry)
  );

  relogio_mod_counter #(.MAX(MAX_MIN)) u_min (
    .i_clk   (clk_100MHz),
    .i_clr   (!reset),
    .i_inc   (w_min_inc),
    .i_dec   (w_min_dec),
    .o_value (minutos),
    .o_carry (w_min_carry)
  );

  relogio_mod_counter #(.MAX(MAX_HORA)) u_hora (
    .i_clk   (clk_100MHz),
    .i_clr   (!reset),
    .i_inc   (w_hora_inc),
    .i_dec   (w_hora_dec),
    .o_value (horas),
    .o_carry ()
  );

  assign modo_ajuste = r_modo;
  assign tick_1hz    = r_tick;

endmodule

// File: tb/tb_relogio_ajuste_ctrl.sv
// Directed bench for relogio_ajuste_ctrl with a 4-cycle second.
// Build with AUTOREPEAT_EN defined to exercise the hold-to-repeat path.
module tb_relogio_ajuste_ctrl;

  logic       clk_100MHz;
  logic       reset;
  logic       btn_modo, btn_mais, btn_menos;
  logic [5:0] segundos, minutos, horas;
  logic [1:0] modo_ajuste;
  logic       tick_1hz;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  relogio_ajuste_ctrl #(
    .TICKS_PER_SEC (4)
`ifdef AUTOREPEAT_EN
    ,
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
`endif
  ) dut (
    .clk_100MHz  (clk_100MHz),
    .reset       (reset),
    .btn_modo    (btn_modo),
    .btn_mais    (btn_mais),
    .btn_menos   (btn_menos),
    .segundos    (segundos),
    .minutos     (minutos),
    .horas       (horas),
    .modo_ajuste (modo_ajuste),
    .tick_1hz    (tick_1hz)
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  // mask = {modo, mais, menos}; effect visible after the first step
  task automatic press(input logic [2:0] mask);
    {btn_modo, btn_mais, btn_menos} = mask;
    step(1);
    {btn_modo, btn_mais, btn_menos} = 3'b000;
    step(1);
  endtask

  task automatic test_reset();
    {btn_modo, btn_mais, btn_menos} = 3'b111;
    reset = 1'b0;
    step(2);
    n_tests++;
    if ({segundos, minutos, horas} !== 18'd0) begin
      $display("FAIL reset_time: got %0d:%0d:%0d want 0:0:0", horas, minutos, segundos);
      n_fail++;
    end
    n_tests++;
    if (modo_ajuste !== 2'b00 || tick_1hz !== 1'b0) begin
      $display("FAIL reset_modo_tick: got modo=%b tick=%b want 00/0", modo_ajuste, tick_1hz);
      n_fail++;
    end
    reset = 1'b1;
    {btn_mais, btn_menos} = 2'b00;
    step(3);
    n_tests++;
    if (modo_ajuste !== 2'b00) begin
      $display("FAIL reset_held_modo: got %b want 00", modo_ajuste);
      n_fail++;
    end
    btn_modo = 1'b0;
    step(1);
  endtask

  task automatic test_rollover();
    do_reset();
    press(3'b100);
    press(3'b001);
    press(3'b100);
    press(3'b001);
    press(3'b100);
    press(3'b001);
    press(3'b001);
    n_tests++;
    if (horas !== 6'd23 || minutos !== 6'd59 || segundos !== 6'd58 || modo_ajuste !== 2'b11) begin
      $display("FAIL rollover_setup: got %0d:%0d:%0d modo=%b want 23:59:58 11",
               horas, minutos, segundos, modo_ajuste);
      n_fail++;
    end
    btn_modo = 1'b1;
    step(1);
    btn_modo = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      n_tests++;
      if (tick_1hz !== ((k == 4) || (k == 8))) begin
        $display("FAIL rollover_tick_k%0d: got %b want %b", k, tick_1hz, (k == 4) || (k == 8));
        n_fail++;
      end
      if (k == 5) begin
        n_tests++;
        if (horas !== 6'd23 || minutos !== 6'd59 || segundos !== 6'd59) begin
          $display("FAIL rollover_first_tick: got %0d:%0d:%0d want 23:59:59", horas, minutos, segundos);
          n_fail++;
        end
      end
      if (k == 9) begin
        n_tests++;
        if (horas !== 6'd0 || minutos !== 6'd0 || segundos !== 6'd0) begin
          $display("FAIL rollover_wrap: got %0d:%0d:%0d want 0:0:0", horas, minutos, segundos);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_mode_cycle();
    int ticks;
    do_reset();
    press(3'b100);
    n_tests++;
    if (modo_ajuste !== 2'b01) begin
      $display("FAIL mode_hora: got %b want 01", modo_ajuste);
      n_fail++;
    end
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      ticks += int'(tick_1hz);
      n_tests++;
      if (segundos !== 6'd0) begin
        $display("FAIL frozen_seg_c%0d: got %0d want 0", i, segundos);
        n_fail++;
      end
    end
    n_tests++;
    if (ticks !== 5) begin
      $display("FAIL adjust_tick_count: got %0d want 5", ticks);
      n_fail++;
    end
    press(3'b100);
    n_tests++;
    if (modo_ajuste !== 2'b10) begin
      $display("FAIL mode_min: got %b want 10", modo_ajuste);
      n_fail++;
    end
    press(3'b100);
    n_tests++;
    if (modo_ajuste !== 2'b11) begin
      $display("FAIL mode_seg: got %b want 11", modo_ajuste);
      n_fail++;
    end
    btn_modo = 1'b1;
    step(1);
    btn_modo = 1'b0;
    n_tests++;
    if (modo_ajuste !== 2'b00) begin
      $display("FAIL mode_normal: got %b want 00", modo_ajuste);
      n_fail++;
    end
    for (int k = 1; k <= 4; k++) begin
      step(1);
      n_tests++;
      if (tick_1hz !== (k == 4)) begin
        $display("FAIL exit_tick_k%0d: got %b want %b", k, tick_1hz, k == 4);
        n_fail++;
      end
    end
    step(1);
    n_tests++;
    if (segundos !== 6'd1) begin
      $display("FAIL exit_first_count: got %0d want 1", segundos);
      n_fail++;
    end
  endtask

  task automatic test_adjust_wrap();
    do_reset();
    press(3'b100);
    press(3'b001);
    n_tests++;
    if (horas !== 6'd23) begin
      $display("FAIL hora_dec_wrap: got %0d want 23", horas);
      n_fail++;
    end
    press(3'b010);
    n_tests++;
    if (horas !== 6'd0) begin
      $display("FAIL hora_inc_wrap: got %0d want 0", horas);
      n_fail++;
    end
    press(3'b010);
    press(3'b010);
    press(3'b100);
    press(3'b001);
    n_tests++;
    if (minutos !== 6'd59) begin
      $display("FAIL min_dec_wrap: got %0d want 59", minutos);
      n_fail++;
    end
    press(3'b010);
    n_tests++;
    if (minutos !== 6'd0 || horas !== 6'd2) begin
      $display("FAIL min_inc_wrap: got min=%0d hr=%0d want 0/2", minutos, horas);
      n_fail++;
    end
    press(3'b100);
    press(3'b001);
    n_tests++;
    if (segundos !== 6'd59 || minutos !== 6'd0) begin
      $display("FAIL seg_dec_wrap: got seg=%0d min=%0d want 59/0", segundos, minutos);
      n_fail++;
    end
    press(3'b010);
    n_tests++;
    if (segundos !== 6'd0 || minutos !== 6'd0) begin
      $display("FAIL seg_inc_wrap: got seg=%0d min=%0d want 0/0", segundos, minutos);
      n_fail++;
    end
  endtask

  task automatic test_simultaneous();
    logic [5:0] exp_min;
    do_reset();
    press(3'b100);
    press(3'b011);
    n_tests++;
    if (horas !== 6'd0 || modo_ajuste !== 2'b01) begin
      $display("FAIL mais_menos: got hr=%0d modo=%b want 0/01", horas, modo_ajuste);
      n_fail++;
    end
    press(3'b010);
    press(3'b110);
    n_tests++;
    if (modo_ajuste !== 2'b10 || horas !== 6'd1 || minutos !== 6'd0) begin
      $display("FAIL modo_mais: got modo=%b hr=%0d min=%0d want 10/1/0", modo_ajuste, horas, minutos);
      n_fail++;
    end
    btn_mais = 1'b1;
    step(20);
    btn_mais = 1'b0;
    step(2);
`ifdef AUTOREPEAT_EN
    exp_min = 6'd4;
`else
    exp_min = 6'd1;
`endif
    n_tests++;
    if (minutos !== exp_min) begin
      $display("FAIL mais_held: got %0d want %0d", minutos, exp_min);
      n_fail++;
    end
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    n_tests++;
    if ({segundos, minutos, horas} !== 18'd0 || modo_ajuste !== 2'b00) begin
      $display("FAIL mid_reset: got %0d:%0d:%0d modo=%b want 0:0:0 00",
               horas, minutos, segundos, modo_ajuste);
      n_fail++;
    end
    step(1);
  endtask

`ifdef AUTOREPEAT_EN
  task automatic test_autorepeat();
    do_reset();
    press(3'b100);
    press(3'b100);
    for (int i = 0; i < 10; i++) press(3'b010);
    n_tests++;
    if (minutos !== 6'd10) begin
      $display("FAIL repeat_setup: got %0d want 10", minutos);
      n_fail++;
    end
    btn_mais = 1'b1;
    step(20);
    btn_mais = 1'b0;
    n_tests++;
    if (minutos !== 6'd14) begin
      $display("FAIL repeat_held: got %0d want 14", minutos);
      n_fail++;
    end
    step(10);
    n_tests++;
    if (minutos !== 6'd14) begin
      $display("FAIL repeat_release: got %0d want 14", minutos);
      n_fail++;
    end
  endtask
`endif

  initial begin
    reset = 1'b0;
    {btn_modo, btn_mais, btn_menos} = 3'b000;
    test_reset();
    test_rollover();
    test_mode_cycle();
    test_adjust_wrap();
    test_simultaneous();
`ifdef AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/relogio_ajuste_ctrl.md
Name: relogio_ajuste_ctrl

Overview:
Timekeeping and adjust controller feeding the clock's display path. Generates the 1 Hz timebase and maintains the HH:MM:SS counters. Runs the adjust-mode FSM from the debounced buttons modo/mais/menos. Drives segundos/minutos/horas/modo_ajuste straight into the display-with-adjust block.

Parameters:
TICKS_PER_SEC, 100_000_000, clk_100MHz cycles per second tick
REPEAT_DELAY, 50_000_000, cycles held before first auto-repeat (AUTOREPEAT_EN only)
REPEAT_PERIOD, 10_000_000, cycles between auto-repeats (AUTOREPEAT_EN only)

Ports:
clk_100MHz  in  1  system clock
reset  in  1  synchronous, active-low reset
btn_modo  in  1  debounced, clk-synchronous mode button
btn_mais  in  1  debounced increment button
btn_menos  in  1  debounced decrement button
segundos  out  6  seconds 0..59
minutos  out  6  minutes 0..59
horas  out  6  hours 0..23
modo_ajuste  out  2  00 normal, 01 hours, 10 minutes, 11 seconds
tick_1hz  out  1  one-cycle pulse each second, all modes

Behaviour:
- Reset: reset==0 at a clk edge -> all outputs 0, FSM NORMAL, prescaler 0, button history regs 0. Applies mid-operation, overrides everything.
- Prescaler: counts 0..TICKS_PER_SEC-1. tick_1hz=1 (registered) in the cycle after count==TICKS_PER_SEC-1. Free-running in every mode. Cleared to 0 on the AJ_SEG->NORMAL transition.
- Edge detect: btn_x_q holds the previous sample. An edge is btn_x & ~btn_x_q. Its effect is visible after the same clock edge on which btn_x is first sampled high (1-cycle latency). Holding a button gives one edge only.
- FSM on a modo edge: NORMAL(00) -> AJ_HORA(01) -> AJ_MIN(10) -> AJ_SEG(11) -> NORMAL.
- NORMAL:
  - tick: segundos+1.
  - 59->0 carries minutos+1.
  - 59->0 carries horas+1.
  - horas 23->0 wraps.
  - mais/menos ignored.
- Adjust modes:
  - Timekeeping frozen; ticks ignored.
  - mais edge: selected field +1, wrapping 59->0 (hours 23->0).
  - menos edge: selected field -1, wrapping 0->59 (hours 0->23).
  - No carry/borrow into other fields.
- Simultaneous events:
  - mais and menos edges in the same cycle: no change.
  - modo edge with mais/menos in the same cycle: mode advances, field unchanged.
  - modo edge coinciding with tick in NORMAL: mode advances, tick still counted.
- Field arithmetic uses 6-bit unsigned compare-before-update. Out-of-range values are unreachable.

Optional Feature:
AUTOREPEAT_EN defined:
- In adjust modes, mais/menos held continuously generates extra pulses.
- First extra pulse comes REPEAT_DELAY cycles after the edge, then one every REPEAT_PERIOD cycles.
- Release, modo edge, or reset clears the repeat counter.
- Both held: no effect.

AUTOREPEAT_EN undefined:
- Edge-only behaviour.
- REPEAT_* unused; no repeat counter synthesized.

Decomposition:
- Package relogio_pkg:
  - typedef enum logic [1:0] modo_t {NORMAL=2'b00, AJ_HORA=2'b01, AJ_MIN=2'b10, AJ_SEG=2'b11}.
  - Constants MAX_SEG=59, MAX_MIN=59, MAX_HORA=23.
- Sub-module relogio_mod_counter (parameter MAX):
  - Inputs inc, dec, clr; outputs value and carry on MAX->0.
  - Instantiated three times.

Test Plan:
1. Reset with buttons high: reset=0 for 2 cycles -> segundos=minutos=horas=0, modo_ajuste=00, tick_1hz=0. Release, hold btn_modo high -> no edge, modo stays 00.
2. Rollover, TICKS_PER_SEC=4: set 23:59:58 via adjust, return to NORMAL. tick_1hz period is 4 cycles; after 2 ticks, horas:minutos:segundos=00:00:00.
3. Mode cycling: 4 btn_modo pulses -> modo_ajuste 01,10,11,00. Across 20 cycles in adjust, segundos unchanged while tick_1hz keeps pulsing. First NORMAL tick comes 4 cycles after exit.
4. Wrap in adjust:
   - AJ_HORA, horas=0, menos -> 23; mais -> 0.
   - AJ_MIN at 59, mais -> 0 with horas unchanged.
   - AJ_SEG at 0, menos -> 59.
5. Simultaneity, macro off:
   - mais+menos same cycle -> field unchanged.
   - modo+mais -> mode advances, field unchanged.
   - mais held 20 cycles -> exactly one increment.
   - reset asserted mid-adjust -> all zero, modo 00 next cycle.
6. AUTOREPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, AJ_MIN from 10: mais held 20 cycles -> increments at cycles 0,8,12,16 -> minutos=14. Release -> no further change.
